// File: rtl/reader_seq_pkg.sv
// Shared types and constants for the reader frame sequencer.
// State encoding, Avalon register word addresses and register bit positions.
package reader_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT_DONE
    } state_t;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_FRAME_LEN = 3'd2;
    localparam logic [2:0] ADDR_PIXEL     = 3'd3;
    localparam logic [2:0] ADDR_COUNT     = 3'd4;
    localparam logic [2:0] ADDR_RESULT    = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_FRAME_DONE = 1;
    localparam int STAT_TIMEOUT    = 2;
    localparam int STAT_FULL       = 3;
    localparam int STAT_EMPTY      = 4;
    localparam int STAT_OVERFLOW   = 5;

endpackage

// File: rtl/pixel_fifo.sv
// Pixel FIFO: head shows the oldest entry, a push is poppable the next cycle (no bypass).
// Push while full is taken only if a pop happens the same cycle; flush empties it synchronously.
module pixel_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign level = count;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reader_sequencer.sv
// Avalon-MM front end that streams a host-loaded pixel frame into the Reader and captures its result.
// One pixel per cycle, pix_enable one cycle after the pop; the stream stalls while the FIFO is empty.
module reader_sequencer
    import reader_seq_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 16,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              pix_enable,
    output logic [DATA_W-1:0] pix_data,
    input  logic              rdr_done,
    input  logic [DATA_W-1:0] rdr_result,
    output logic              irq
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  frame_len;
    logic [CNT_W-1:0]  count;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] result;
    logic              irq_en;
    logic              frame_done;
    logic              timeout;
    logic              overflow;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    logic wr_ctrl, wr_status, wr_len, pix_push, start_req, abort_req, busy;
    logic pop, go, done_hit, tmo_hit;
    logic [31:0] rd_mux;

    assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_status = avs_write && (avs_address == ADDR_STATUS);
    assign wr_len    = avs_write && (avs_address == ADDR_FRAME_LEN);
    assign pix_push  = avs_write && (avs_address == ADDR_PIXEL);
    assign start_req = wr_ctrl && avs_writedata[CTRL_START];
    assign abort_req = wr_ctrl && avs_writedata[CTRL_ABORT];
    assign busy      = (state != ST_IDLE);
    assign irq       = irq_en && (frame_done || timeout);

    pixel_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (abort_req),
        .push  (pix_push),
        .pop   (pop),
        .din   (avs_writedata[DATA_W-1:0]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        go        = 1'b0;
        done_hit  = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req && frame_len != '0) begin
                    state_nxt = ST_STREAM;
                    go        = 1'b1;
                end
            end
            ST_STREAM: begin
                if (!fifo_empty && count != frame_len) begin
                    pop = 1'b1;
                    if ((count + 1'b1) == frame_len) state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Expire after DONE_TIMEOUT cycles in this state; a done in that cycle still wins.
                if (rdr_done) begin
                    done_hit  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timer == TMR_W'(DONE_TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_req) begin
            state_nxt = ST_IDLE;
            pop       = 1'b0;
            go        = 1'b0;
            done_hit  = 1'b0;
            tmo_hit   = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL:      rd_mux[CTRL_IRQ_EN] = irq_en;
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY]       = busy;
                rd_mux[STAT_FRAME_DONE] = frame_done;
                rd_mux[STAT_TIMEOUT]    = timeout;
                rd_mux[STAT_FULL]       = fifo_full;
                rd_mux[STAT_EMPTY]      = fifo_empty;
                rd_mux[STAT_OVERFLOW]   = overflow;
                rd_mux[15:8]            = 8'(fifo_level);
            end
            ADDR_FRAME_LEN: rd_mux[CNT_W-1:0]  = frame_len;
            ADDR_COUNT:     rd_mux[CNT_W-1:0]  = count;
            ADDR_RESULT:    rd_mux[DATA_W-1:0] = result;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            frame_len    <= '0;
            count        <= '0;
            timer        <= '0;
            result       <= '0;
            irq_en       <= 1'b0;
            frame_done   <= 1'b0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
            pix_enable   <= 1'b0;
            pix_data     <= '0;
            avs_readdata <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= (state == ST_WAIT_DONE) ? timer + 1'b1 : '0;
            pix_enable <= pop;
            if (pop) begin
                pix_data <= fifo_head;
                count    <= count + 1'b1;
            end
            if (go) count <= '0;
            if (wr_ctrl) irq_en <= avs_writedata[CTRL_IRQ_EN];
            if (wr_len && !busy) frame_len <= avs_writedata[CNT_W-1:0];
            // Clears are applied before the set events so a same-cycle set wins.
            if (wr_status) begin
                if (avs_writedata[STAT_FRAME_DONE]) frame_done <= 1'b0;
                if (avs_writedata[STAT_TIMEOUT])    timeout    <= 1'b0;
                if (avs_writedata[STAT_OVERFLOW])   overflow   <= 1'b0;
            end
            if (go) begin
                frame_done <= 1'b0;
                timeout    <= 1'b0;
            end
            if (done_hit) begin
                frame_done <= 1'b1;
                result     <= rdr_result;
            end
            if (tmo_hit) timeout <= 1'b1;
            if (pix_push && fifo_full && !pop) overflow <= 1'b1;
            if (avs_read) avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_reader_sequencer.sv
// Scoreboard bench: a frame-level model schedules expected pixels and register reads; a monitor checks them.
module tb_reader_sequencer;
    import reader_seq_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        pix_enable;
    logic [31:0] pix_data;
    logic        rdr_done = 1'b0;
    logic [31:0] rdr_result = '0;
    logic        irq;

    always #5 clk = ~clk;

    reader_sequencer #(
        .DATA_W(32), .FIFO_DEPTH(16), .CNT_W(16), .DONE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .pix_enable(pix_enable), .pix_data(pix_data),
        .rdr_done(rdr_done), .rdr_result(rdr_result), .irq(irq)
    );

    typedef struct { logic [31:0] dat; int cyc; } pix_t;
    typedef struct { logic [2:0] addr; logic [31:0] exp; } rd_t;

    pix_t pix_q[$];
    rd_t  rd_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Frame-level reference model.
    logic [31:0] mfifo[$];
    int          m_len, m_cnt, m_need, m_t, m_last;
    bit          m_fd, m_to, m_ovf, m_ien, m_busy;
    logic [31:0] m_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic rd_prev = 1'b0;
    always @(negedge clk) begin
        rd_t  r;
        pix_t p;
        if (reset) begin
            rd_prev = 1'b0;
        end else begin
            if (rd_prev) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", avs_readdata, 32'hxxxx_xxxx);
                end else begin
                    r = rd_q.pop_front();
                    check($sformatf("rd_addr%0d", r.addr), avs_readdata, r.exp);
                end
            end
            if (pix_enable) begin
                if (pix_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_unexpected: got pixel 0x%08h expected none (cycle %0d)", pix_data, cyc);
                end else begin
                    p = pix_q.pop_front();
                    check("pix_data", pix_data, p.dat);
                    check("pix_cycle", 32'(cyc), 32'(p.cyc));
                end
            end
            rd_prev = avs_read;
        end
    end

    task automatic model_reset();
        mfifo.delete();
        m_len = 0; m_cnt = 0; m_need = 0; m_t = 0; m_last = 0;
        m_fd = 0; m_to = 0; m_ovf = 0; m_ien = 0; m_busy = 0; m_res = '0;
    endtask

    task automatic settle(input int x);
        if (m_busy && m_need == 0 && x >= m_last + TMO) begin
            m_to = 1; m_busy = 0;
        end
    endtask

    task automatic schedule(input logic [31:0] d, input int n);
        int pop_c;
        pop_c = (n + 1 > m_t) ? n + 1 : m_t;
        pix_q.push_back('{d, pop_c + 1});
        m_t = pop_c + 1;
        m_last = pop_c + 1;
        m_cnt++;
        m_need--;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [31:0] d, input int n);
        settle(n);
        case (a)
            ADDR_CTRL: begin
                m_ien = d[2];
                if (d[1]) begin
                    while (pix_q.size() > 0 && pix_q[$].cyc > n) begin
                        void'(pix_q.pop_back());
                        m_cnt--;
                    end
                    m_need = 0; m_busy = 0;
                    mfifo.delete();
                end else if (d[0] && !m_busy && m_len != 0) begin
                    m_busy = 1; m_cnt = 0; m_fd = 0; m_to = 0;
                    m_need = m_len; m_t = n + 1;
                    while (m_need > 0 && mfifo.size() > 0) schedule(mfifo.pop_front(), n);
                end
            end
            ADDR_STATUS: begin
                if (d[1]) m_fd = 0;
                if (d[2]) m_to = 0;
                if (d[5]) m_ovf = 0;
            end
            ADDR_FRAME_LEN: if (!m_busy) m_len = int'(d[15:0]);
            ADDR_PIXEL: begin
                if (m_need > 0)              schedule(d, n);
                else if (mfifo.size() < 16)  mfifo.push_back(d);
                else                         m_ovf = 1;
            end
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        model_write(a, d, cyc);
        @(posedge clk); #2;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        logic [31:0] e;
        int lvl;
        settle(cyc);
        lvl = mfifo.size();
        case (a)
            ADDR_CTRL:      e = {29'b0, m_ien, 2'b0};
            ADDR_STATUS:    e = {16'b0, 8'(lvl), 2'b0, m_ovf, (lvl == 0), (lvl == 16), m_to, m_fd, m_busy};
            ADDR_FRAME_LEN: e = 32'(m_len);
            ADDR_COUNT:     e = 32'(m_cnt);
            ADDR_RESULT:    e = m_res;
            default:        e = '0;
        endcase
        avs_address = a; avs_read = 1'b1;
        rd_q.push_back('{a, e});
        @(posedge clk); #2;
        avs_read = 1'b0;
    endtask

    task automatic pulse_done(input logic [31:0] r);
        settle(cyc);
        if (m_busy && m_need == 0 && cyc >= m_last) begin
            m_fd = 1; m_res = r; m_busy = 0;
        end
        rdr_done = 1'b1; rdr_result = r;
        @(posedge clk); #2;
        rdr_done = 1'b0;
    endtask

    task automatic chk_irq(input string name);
        settle(cyc);
        check(name, {31'b0, irq}, {31'b0, m_ien & (m_fd | m_to)});
    endtask

    task automatic wait_frame();
        while (cyc <= m_last) idle(1);
    endtask

    task automatic do_reset();
        int n;
        n = cyc;
        reset = 1'b1;
        #1;
        check("rst_pix_enable", {31'b0, pix_enable}, 32'h0);
        check("rst_pix_data", pix_data, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        while (pix_q.size() > 0 && pix_q[$].cyc >= n) void'(pix_q.pop_back());
        model_reset();
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic push_n(input int k);
        for (int i = 0; i < k; i++) wr(ADDR_PIXEL, $urandom);
    endtask

    initial begin
        int e;
        model_reset();
        @(posedge clk); #2;
        do_reset();
        for (int a = 0; a < 7; a++) rd(3'(a));

        // Four-pixel frame with irq, then W1C of frame_done.
        wr(ADDR_FRAME_LEN, 32'd4);
        rd(ADDR_FRAME_LEN);
        wr(ADDR_PIXEL, 32'h11); wr(ADDR_PIXEL, 32'h22);
        wr(ADDR_PIXEL, 32'h33); wr(ADDR_PIXEL, 32'h44);
        wr(ADDR_CTRL, 32'h5);
        wait_frame();
        pulse_done(32'hCAFE);
        rd(ADDR_RESULT); rd(ADDR_COUNT); rd(ADDR_STATUS); rd(ADDR_CTRL);
        chk_irq("irq_after_done");
        wr(ADDR_STATUS, 32'h2);
        chk_irq("irq_after_w1c");
        rd(ADDR_STATUS);

        // Trickle-fed frame: each pulse lands two cycles after its push.
        wr(ADDR_FRAME_LEN, 32'd3);
        wr(ADDR_CTRL, 32'h5);
        for (int i = 0; i < 3; i++) begin
            wr(ADDR_PIXEL, $urandom);
            idle(2);
            rd(ADDR_STATUS);
            idle(1);
        end
        wait_frame();
        rd(ADDR_STATUS);
        pulse_done($urandom);
        rd(ADDR_STATUS); rd(ADDR_RESULT);
        wr(ADDR_STATUS, 32'h26);

        // Overflow: the 17th push is dropped.
        push_n(17);
        rd(ADDR_STATUS);
        wr(ADDR_FRAME_LEN, 32'd16);
        wr(ADDR_CTRL, 32'h5);
        wait_frame();
        pulse_done($urandom);
        rd(ADDR_STATUS); rd(ADDR_COUNT);
        wr(ADDR_STATUS, 32'h26);
        rd(ADDR_STATUS);

        // Timeout after exactly TMO cycles in WAIT_DONE.
        wr(ADDR_FRAME_LEN, 32'd1);
        push_n(1);
        wr(ADDR_CTRL, 32'h5);
        wait_frame();
        e = m_last;
        while (cyc < e + TMO - 1) idle(1);
        rd(ADDR_STATUS);
        rd(ADDR_STATUS);
        chk_irq("irq_timeout");
        wr(ADDR_STATUS, 32'h4);
        chk_irq("irq_timeout_clr");

        // Done in the expiry cycle beats the timeout.
        push_n(1);
        wr(ADDR_CTRL, 32'h5);
        wait_frame();
        e = m_last;
        while (cyc < e + TMO - 1) idle(1);
        pulse_done(32'h0BAD_F00D);
        rd(ADDR_STATUS); rd(ADDR_RESULT);
        wr(ADDR_STATUS, 32'h26);

        // Abort after two pulses flushes the FIFO and keeps COUNT.
        wr(ADDR_FRAME_LEN, 32'd5);
        push_n(5);
        wr(ADDR_CTRL, 32'h5);
        idle(2);
        wr(ADDR_CTRL, 32'h6);
        idle(3);
        rd(ADDR_STATUS); rd(ADDR_COUNT);
        chk_irq("irq_abort");

        // Same frame, cut short by reset.
        push_n(5);
        wr(ADDR_CTRL, 32'h5);
        idle(2);
        do_reset();
        idle(2);
        for (int a = 0; a < 7; a++) rd(3'(a));

        // Ignored starts and FRAME_LEN writes; stray done while idle.
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_STATUS);
        wr(ADDR_FRAME_LEN, 32'd2);
        push_n(1);
        wr(ADDR_CTRL, 32'h1);
        idle(3);
        wr(ADDR_FRAME_LEN, 32'd7);
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_FRAME_LEN); rd(ADDR_COUNT); rd(ADDR_STATUS);
        push_n(1);
        wait_frame();
        pulse_done(32'h1234_5678);
        rd(ADDR_STATUS); rd(ADDR_COUNT);
        idle(2);
        pulse_done(32'hDEAD_BEEF);
        rd(ADDR_RESULT); rd(ADDR_STATUS);
        wr(ADDR_STATUS, 32'h26);

        // Randomized frames with random done timing (some time out).
        for (int f = 0; f < 8; f++) begin
            int len, k, d, target;
            len = int'($urandom_range(1, 8));
            k   = int'($urandom_range(0, len));
            wr(ADDR_FRAME_LEN, 32'(len));
            push_n(k);
            wr(ADDR_CTRL, 32'h5);
            for (int i = k; i < len; i++) begin
                idle(int'($urandom_range(0, 3)));
                wr(ADDR_PIXEL, $urandom);
            end
            wait_frame();
            d = int'($urandom_range(0, TMO + 2));
            target = m_last + d;
            while (cyc < target) idle(1);
            pulse_done($urandom);
            rd(ADDR_STATUS); rd(ADDR_COUNT); rd(ADDR_RESULT);
            chk_irq("irq_random");
            wr(ADDR_STATUS, 32'h26);
            rd(ADDR_STATUS);
        end

        idle(4);
        check("pix_q_drained", 32'(pix_q.size()), 32'h0);
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reader_sequencer.md
# reader_sequencer

Sequences pixel frames into the Reader datapath on behalf of the Nios/Avalon host. The host writes a frame length and pushes pixels into an internal FIFO. The block then issues them to the Reader one per cycle, waits for the Reader's `done`, captures its result and raises an interrupt. It sits between the Avalon-MM interconnect and the Reader core, in place of a direct host-to-Reader write path.

## Interface
- `DATA_W`, 32: pixel and result width.
- `FIFO_DEPTH`, 16: pixel FIFO entries; must be a power of two.
- `CNT_W`, 16: frame-length and pixel-counter width.
- `DONE_TIMEOUT`, 1024: cycles to wait for `rdr_done` after the last pixel.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `avs_address` in 3: word address.
- `avs_write` in 1: host write strobe.
- `avs_writedata` in 32: host write data.
- `avs_read` in 1: host read strobe.
- `avs_readdata` out 32: registered read data, read latency 1.
- `pix_enable` out 1: one-cycle strobe, pixel valid to Reader.
- `pix_data` out DATA_W: pixel to Reader.
- `rdr_done` in 1: Reader frame-complete pulse.
- `rdr_result` in DATA_W: Reader output, sampled when `rdr_done`=1.
- `irq` out 1: interrupt, level.

## Operation
- Register map (word address):
  - 0 CTRL: write bit0 = start, bit1 = abort, bit2 = irq_en. Read returns irq_en in bit2; all other bits read 0.
  - 1 STATUS, read:
    - bit0 busy, bit1 frame_done, bit2 timeout, bit3 fifo_full, bit4 fifo_empty, bit5 overflow.
    - [15:8] FIFO level, zero-extended.
    - Writing 1 to bit1, bit2 or bit5 clears that bit (W1C).
  - 2 FRAME_LEN: read/write, CNT_W bits. Writes while busy are ignored.
  - 3 PIXEL: write pushes `avs_writedata` into the FIFO. If the FIFO is full and no pop occurs that cycle, the data is dropped and overflow is set (sticky).
  - 4 COUNT: read only, pixels issued in the current or last frame.
  - 5 RESULT: read only, last captured `rdr_result`.
  - Addresses 6–7 read 0; writes to them are ignored.
- FSM states: IDLE, STREAM, WAIT_DONE.
  - IDLE → STREAM on start with FRAME_LEN≠0. This transition clears COUNT, frame_done and timeout. Start with FRAME_LEN=0 is ignored.
  - In STREAM, each cycle with the FIFO non-empty pops one entry and increments COUNT. When the pop makes COUNT equal FRAME_LEN, the next state is WAIT_DONE and the timer clears.
  - WAIT_DONE → IDLE when `rdr_done`=1: RESULT ← `rdr_result`, frame_done ← 1.
  - WAIT_DONE → IDLE when the timer reaches DONE_TIMEOUT: timeout ← 1.
- Abort from any state: go to IDLE and flush the FIFO. No flags are set and COUNT is kept.
- Start while busy is ignored. `rdr_done` outside WAIT_DONE is ignored.
- busy is 1 in STREAM and WAIT_DONE.
- `irq` = irq_en & (frame_done | timeout), decoded from registers.
- COUNT saturates at FRAME_LEN and never wraps.

## Timing
- Reset values: every output 0 (`avs_readdata`, `pix_enable`, `pix_data`, `irq`). Registers: FIFO empty, COUNT=0, FRAME_LEN=0, RESULT=0, all flags 0, state IDLE.
- Reset mid-frame returns the block to IDLE immediately (asynchronous); no further `pix_enable` pulses.
- Pop in cycle N gives `pix_enable`=1 with that pixel in cycle N+1. `pix_data` holds its value when `pix_enable`=0.
- Start written in cycle N: STREAM in N+1, first pop in N+1 if the FIFO is non-empty, first `pix_enable` in N+2.
- No push-to-pop bypass: a push in cycle N is poppable in N+1 at the earliest.
- Push and pop in the same cycle: both take effect and the level is unchanged. This is allowed when the FIFO is full.
- `avs_readdata` is valid in the cycle after `avs_read`.
- `rdr_done` arriving in the same cycle as the timer expiry: done wins and timeout stays 0.
- The timer counts cycles spent in WAIT_DONE, starting at 0 on entry.
- Flags set by an event are visible on STATUS reads issued the following cycle.
- A W1C write in the same cycle as a set event: the set wins.

## Structure
- Package `reader_seq_pkg`: FSM state enum, register address constants, STATUS bit indices.
- Sub-module `pixel_fifo`:
  - Synchronous FIFO, DATA_W × FIFO_DEPTH.
  - Ports: push, pop, data in, head, full, empty, level.
  - Asynchronous active-high reset plus a synchronous flush input.
- The top level holds the Avalon decode, FSM, counter, timer and flags.

## Test plan
- FRAME_LEN=4, push 0x11/0x22/0x33/0x44, irq_en=1, start → `pix_enable` high for 4 consecutive cycles carrying 0x11..0x44 in order. Then `rdr_done` with `rdr_result`=0xCAFE → RESULT=0xCAFE, COUNT=4, STATUS bit1=1, `irq`=1. W1C of bit1 → `irq`=0.
- FRAME_LEN=3, start with the FIFO empty, then push one pixel every 5 cycles → each `pix_enable` pulse occurs 2 cycles after its push; busy stays 1 until `rdr_done`.
- Push 17 pixels while idle → level=16, fifo_full=1, overflow=1; the 17th value is absent from the subsequent frame.
- `DONE_TIMEOUT`=8, FRAME_LEN=1, `rdr_done` never asserted → timeout=1 exactly 8 cycles after WAIT_DONE entry. With `rdr_done` in that same cycle instead → frame_done=1, timeout=0.
- FRAME_LEN=5, abort after 2 pulses → no `pix_enable` from the next cycle, fifo_empty=1, busy=0, COUNT=2, no flags.
- Repeat the FRAME_LEN=5 run with reset asserted instead of abort → all registers and outputs at reset values.
- Start with FRAME_LEN=0, and start or FRAME_LEN write while busy → all ignored: state, COUNT and FRAME_LEN unchanged.
